// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port general-purpose register file.
// Reads are combinational, with optional same-cycle forwarding of writes.
// A busy bit per register tracks in-flight producers.
// A sequential clear engine zeroes the array after reset or on request.
// Register 0 is hardwired to zero.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  claim_en,
    input  logic [ADDR_W-1:0]     claim_addr
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREGS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] clr_cnt;
    logic [IDX_W-1:0] clr_cnt_nxt;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Storage is deliberately not reset; the clear engine initialises it.
    logic [XLEN-1:0]  gpr [NREGS];

    // Array indices: upper address bits are dropped, so addresses alias.
    logic [IDX_W-1:0] rd_idx [NRD];
    logic [IDX_W-1:0] wr_idx [NWR];
    logic [IDX_W-1:0] claim_idx;

    // A write is accepted only in RUN and never to register 0.
    logic [NWR-1:0]   wr_ok;
    logic             claim_ok;

    // Upper address bits intentionally have no effect.
    logic             unused_addr_hi;

    assign unused_addr_hi = ^{rd_addr, wr_addr, claim_addr};

    for (genvar g = 0; g < NRD; g++) begin : g_rd_idx
        assign rd_idx[g] = rd_addr[g*ADDR_W +: IDX_W];
    end

    for (genvar g = 0; g < NWR; g++) begin : g_wr_idx
        assign wr_idx[g] = wr_addr[g*ADDR_W +: IDX_W];
        assign wr_ok[g]  = (state == RUN) && wr_en[g] && (wr_addr[g*ADDR_W +: IDX_W] != '0);
    end

    assign claim_idx = claim_addr[IDX_W-1:0];
    assign claim_ok  = (state == RUN) && claim_en && (claim_idx != '0);
    assign ready     = (state == RUN);

    // Control registers: FSM state, clear counter and busy scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= FIRST_IDX;
            busy    <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next state: walk the clear counter, then update the scoreboard in RUN.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy_nxt    = busy;
        case (state)
            CLEAR: begin
                busy_nxt = '0;
                if (clear_req) begin
                    clr_cnt_nxt = FIRST_IDX;
                end else if (clr_cnt == LAST_IDX) begin
                    state_nxt = RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = FIRST_IDX;
                    busy_nxt    = '0;
                end else begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_ok[j]) begin
                            busy_nxt[wr_idx[j]] = 1'b0;
                        end
                    end
                    // A claim after a write to the same register marks the new producer.
                    if (claim_ok) begin
                        busy_nxt[claim_idx] = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = FIRST_IDX;
                busy_nxt    = '0;
            end
        endcase
    end

    // Array update: the clear engine in CLEAR, port writes in RUN (the highest port wins).
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            gpr[clr_cnt] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j]) begin
                    gpr[wr_idx[j]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read ports: zero until ready and for register 0, otherwise forwarded or stored data.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ready && (rd_idx[i] != '0)) begin
                rd_data[i*XLEN +: XLEN] = gpr[rd_idx[i]];
                if (BYPASS) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_ok[j] && (wr_idx[j] == rd_idx[i])) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        end
                    end
                end
                rd_busy[i] = busy[rd_idx[i]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: table-driven vectors checked through an expected-value queue,
// plus hand-written sequences for the clear engine and reset corner cases.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int NWR    = 2;

    logic                  clk;
    logic                  rst;
    logic                  clear_req;
    logic                  ready;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*XLEN-1:0]   wr_data;
    logic                  claim_en;
    logic [ADDR_W-1:0]     claim_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ce;
        logic [4:0]  ca;
        logic        cr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        er;
    } vec_t;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        er;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[20];

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W),
        .NRD   (NRD),
        .NWR   (NWR),
        .BYPASS(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .claim_en  (claim_en),
        .claim_addr(claim_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ce, input logic [4:0] ca, input logic cr,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input logic er);
        vec_t v;
        v.we = we;   v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ce = ce;   v.ca = ca;   v.cr = cr;   v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0;   v.e1 = e1;   v.eb = eb;   v.er = er;
        return v;
    endfunction

    function automatic vec_t rd(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input logic er);
        return mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, ra0, ra1, e0, e1, eb, er);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clear_req  = 1'b0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
        rd_addr    = '0;
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // One cycle: drive after the edge, queue the expectation, compare on the falling edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t ex;
        @(posedge clk);
        #1;
        wr_en      = v.we;
        wr_addr    = {v.wa1, v.wa0};
        wr_data    = {v.wd1, v.wd0};
        claim_en   = v.ce;
        claim_addr = v.ca;
        clear_req  = v.cr;
        rd_addr    = {v.ra1, v.ra0};
        e.e0 = v.e0;
        e.e1 = v.e1;
        e.eb = v.eb;
        e.er = v.er;
        sbq.push_back(e);
        @(negedge clk);
        ex = sbq.pop_front();
        check({tag, "_rd0"},   rd_data[31:0],      ex.e0);
        check({tag, "_rd1"},   rd_data[63:32],     ex.e1);
        check({tag, "_busy"},  {30'd0, rd_busy},   {30'd0, ex.eb});
        check({tag, "_ready"}, {31'd0, ready},     {31'd0, ex.er});
    endtask

    // Caller is positioned just after a rising edge; counts falling edges with ready low.
    task automatic count_clear(input string nm, input int exp_n);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                n++;
                next_drive();
            end
        end
        check(nm, n, exp_n);
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            step(rd(5'(r), 5'(r + 16), 32'd0, 32'd0, 2'b00, 1'b1), $sformatf("%s_x%0d", tag, r));
        end
    endtask

    initial begin
        //            we     wa0    wd0           wa1    wd1     ce    ca     cr    ra0    ra1    e0            e1            eb     er
        tbl[0]  = mk(2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'd0,  1'b0, 5'd0,  1'b0, 5'd5,  5'd6,  32'hDEADBEEF, 32'd0,        2'b00, 1'b1);
        tbl[1]  = rd(5'd5,  5'd0,  32'hDEADBEEF, 32'd0,        2'b00, 1'b1);
        tbl[2]  = mk(2'b11, 5'd7,  32'h11,       5'd7,  32'h22, 1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 1'b1);
        tbl[3]  = rd(5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 1'b1);
        tbl[4]  = mk(2'b01, 5'd0,  32'hFF,       5'd0,  32'd0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd7,  32'd0,        32'h22,       2'b00, 1'b1);
        tbl[5]  = rd(5'd0,  5'd16, 32'd0,        32'd0,        2'b00, 1'b1);
        tbl[6]  = mk(2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b1, 5'd3,  1'b0, 5'd3,  5'd3,  32'd0,        32'd0,        2'b00, 1'b1);
        tbl[7]  = rd(5'd3,  5'd4,  32'd0,        32'd0,        2'b01, 1'b1);
        tbl[8]  = mk(2'b10, 5'd0,  32'd0,        5'd3,  32'h33, 1'b1, 5'd3,  1'b0, 5'd3,  5'd3,  32'h33,       32'h33,       2'b11, 1'b1);
        tbl[9]  = rd(5'd3,  5'd3,  32'h33,       32'h33,       2'b11, 1'b1);
        tbl[10] = mk(2'b01, 5'd3,  32'h44,       5'd0,  32'd0,  1'b0, 5'd0,  1'b0, 5'd3,  5'd4,  32'h44,       32'd0,        2'b01, 1'b1);
        tbl[11] = rd(5'd3,  5'd4,  32'h44,       32'd0,        2'b00, 1'b1);
        tbl[12] = mk(2'b01, 5'd17, 32'hA5,       5'd0,  32'd0,  1'b0, 5'd0,  1'b0, 5'd1,  5'd17, 32'hA5,       32'hA5,       2'b00, 1'b1);
        tbl[13] = rd(5'd1,  5'd17, 32'hA5,       32'hA5,       2'b00, 1'b1);
        tbl[14] = mk(2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'd0,        32'd0,        2'b00, 1'b1);
        tbl[15] = rd(5'd0,  5'd16, 32'd0,        32'd0,        2'b00, 1'b1);
        tbl[16] = mk(2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b1, 5'd25, 1'b0, 5'd9,  5'd25, 32'd0,        32'd0,        2'b00, 1'b1);
        tbl[17] = rd(5'd9,  5'd25, 32'd0,        32'd0,        2'b11, 1'b1);
        tbl[18] = mk(2'b11, 5'd9,  32'd1,        5'd10, 32'd2,  1'b1, 5'd10, 1'b0, 5'd9,  5'd10, 32'd1,        32'd2,        2'b01, 1'b1);
        tbl[19] = rd(5'd9,  5'd10, 32'd1,        32'd2,        2'b10, 1'b1);

        // Reset state, then the initial clear sequence.
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        rd_addr = {5'd3, 5'd1};
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rd0", rd_data[31:0], 32'd0);
        check("rst_busy", {30'd0, rd_busy}, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        count_clear("init_clear_len", 15);
        read_all_zero("init");

        for (int k = 0; k < 20; k++) begin
            step(tbl[k], $sformatf("vec%0d", k));
        end

        // clear_req in RUN; a write and a claim during CLEAR are dropped.
        step(mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd10, 5'd5,
                32'd2, 32'hDEADBEEF, 2'b01, 1'b1), "creq_trig");
        for (int j = 1; j <= 7; j++) begin
            step(rd(5'd10, 5'd5, 32'd0, 32'd0, 2'b00, 1'b0), $sformatf("creq_c%0d", j));
        end
        step(mk(2'b01, 5'd4, 32'h77, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd4,
                32'd0, 32'd0, 2'b00, 1'b0), "creq_wr_drop");
        next_drive();
        count_clear("creq_clear_rest", 7);
        read_all_zero("creq");

        // rst in RUN drops the busy bits and restarts the clear engine.
        step(mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd6, 5'd0,
                32'd0, 32'd0, 2'b00, 1'b1), "claim6");
        step(rd(5'd6, 5'd0, 32'd0, 32'd0, 2'b01, 1'b1), "claim6_chk");
        next_drive();
        rst     = 1'b1;
        rd_addr = {5'd0, 5'd6};
        @(negedge clk);
        check("rst_run_ready", {31'd0, ready}, 32'd0);
        check("rst_run_busy", {30'd0, rd_busy}, 32'd0);
        next_drive();
        rst = 1'b0;
        count_clear("rst_run_clear_len", 15);
        step(rd(5'd6, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1), "rst_run_after");

        // rst asserted in the middle of CLEAR.
        step(mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0,
                32'd0, 32'd0, 2'b00, 1'b1), "mid_trig");
        next_drive();
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("midclr_ready%0d", j), {31'd0, ready}, 32'd0);
            next_drive();
        end
        rst = 1'b1;
        @(negedge clk);
        check("midclr_rst_ready", {31'd0, ready}, 32'd0);
        next_drive();
        rst = 1'b0;
        count_clear("midclr_clear_len", 15);

        // clear_req during CLEAR restarts the count.
        step(mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0,
                32'd0, 32'd0, 2'b00, 1'b1), "rs_trig");
        next_drive();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("rs_ready%0d", j), {31'd0, ready}, 32'd0);
            next_drive();
        end
        clear_req = 1'b1;
        @(negedge clk);
        check("rs_req_ready", {31'd0, ready}, 32'd0);
        next_drive();
        count_clear("restart_clear_len", 15);

        // Normal operation resumes.
        step(mk(2'b01, 5'd2, 32'hCAFE, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd18,
                32'hCAFE, 32'hCAFE, 2'b00, 1'b1), "final_wr");
        step(rd(5'd2, 5'd18, 32'hCAFE, 32'hCAFE, 2'b00, 1'b1), "final_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
